spram_param_be: RTL and testbench
=================================

SPRAM_PARAM_BE -- requirements
Module: spram_param_be

Interface
REQ-001 The block SHALL have a parameter AWIDTH, default 11, giving the address width.
REQ-002 The block SHALL have a parameter NUM_WORDS, default 2048, giving the memory depth (≤ 2^AWIDTH).
REQ-003 The block SHALL have a parameter DWIDTH, default 60, giving the word width.
REQ-004 The block SHALL have a parameter BWIDTH, default 10, giving the byte-lane width; DWIDTH SHALL be a multiple of BWIDTH, with NBYTES = DWIDTH/BWIDTH.
REQ-005 The block SHALL have a parameter RD_LATENCY, default 1, with legal values 1 or 2 cycles from accept to out_valid.
REQ-006 The block SHALL have a parameter WR_MODE, default 1, encoded 0 = read-first, 1 = no-change, 2 = write-first.
REQ-007 clk  input  1  the single clock; all logic is rising-edge.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 req  input  1  access request.
REQ-010 ready  output  1  access accepted when req && ready.
REQ-011 wren  input  1  1 = write, 0 = read; qualified by req.
REQ-012 byte_en  input  NBYTES  per-lane write enable; lane i covers bits [i*BWIDTH +: BWIDTH].
REQ-013 address  input  AWIDTH  word address.
REQ-014 data  input  DWIDTH  write data.
REQ-015 clear_req  input  1  starts a zero-fill of the whole array.
REQ-016 out  output  DWIDTH  registered read data.
REQ-017 out_valid  output  1  one-cycle pulse per returned word.

Function
REQ-018 The control FSM SHALL have two states: CLEAR (ready=0, one word zeroed per cycle, counter 0..NUM_WORDS-1) and IDLE (ready = !clear_req).
REQ-019 CLEAR SHALL exit to IDLE on the cycle after the counter write at NUM_WORDS-1, so a clear lasts exactly NUM_WORDS cycles.
REQ-020 In IDLE, clear_req=1 SHALL enter CLEAR next cycle with the counter at 0; clear_req SHALL have priority over req, and no access is accepted that cycle.
REQ-021 clear_req while in CLEAR SHALL be ignored (no restart).
REQ-022 An accepted write SHALL update only the lanes with byte_en=1; a write with byte_en all zero SHALL leave memory unchanged.
REQ-023 An accepted read accepted at cycle t SHALL drive out with ram[address] and out_valid=1 at cycle t+RD_LATENCY.
REQ-024 On an accepted write in WR_MODE 0, the block SHALL return the pre-write word with out_valid at t+RD_LATENCY.
REQ-025 On an accepted write in WR_MODE 2, the block SHALL return the post-write merged word with out_valid at t+RD_LATENCY.
REQ-026 On an accepted write in WR_MODE 1, out SHALL hold its previous value and no out_valid is produced.
REQ-027 Back-to-back accesses SHALL be accepted every cycle at full throughput, returning in order.
REQ-028 Reads already in the output pipeline when CLEAR begins SHALL complete with their pre-clear data.
REQ-029 An address ≥ NUM_WORDS SHALL be ignored on write and SHALL return 0 on read, with out_valid still asserted.

Reset
REQ-030 reset SHALL force out=0, out_valid=0, flush pipeline valid bits, state=CLEAR, counter=0, and ready=0.
REQ-031 reset asserted mid-clear SHALL restart the clear from address 0.
REQ-032 After reset deasserts, ready SHALL rise exactly NUM_WORDS cycles later.
REQ-033 Memory contents SHALL be reset only via the clear sequence, never directly.

Structure
REQ-034 The WR_MODE encodings and the FSM state encodings SHALL live in the shared package spram_pkg.
REQ-035 The clear FSM and counter SHALL be the sub-module spram_clear_ctrl.
REQ-036 The array and datapath SHALL stay in spram_param_be, with an inferable behavioural array.

Verification
REQ-037 Reset, then hold idle -> ready rises exactly 2048 cycles after reset falls; a read of address 5 returns 0 with out_valid one cycle later.
REQ-038 Write 0x0123456789ABCDE to address 0x10 with byte_en=6'b111111, then read it -> out=0x0123456789ABCDE, out_valid a single one-cycle pulse.
REQ-039 Write 0xFFFFFFFFFFFFFFF, then write 0 with byte_en=6'b000001, then read -> 0xFFFFFFFFFFFFC00.
REQ-040 Address 3 holds 0xA; write 0xB -> WR_MODE 0 returns 0xA, WR_MODE 2 returns 0xB, WR_MODE 1 gives no out_valid and out unchanged.
REQ-041 RD_LATENCY=2 with back-to-back reads of addresses 1, 2, 3 -> three consecutive out_valid cycles starting at t+2, in order.
REQ-042 Read accepted, then clear_req raised next cycle -> the read returns old data; reset at clear count 100 -> ready rises 2048 cycles after reset falls.

Source files
------------

// File: rtl/spram_pkg.sv
// Shared encodings for the byte-enabled single-port RAM:
// write-collision modes and the clear controller state.
package spram_pkg;

    localparam int WR_READ_FIRST  = 0;
    localparam int WR_NO_CHANGE   = 1;
    localparam int WR_WRITE_FIRST = 2;

    typedef enum logic {
        CLR_CLEAR = 1'b0,
        CLR_IDLE  = 1'b1
    } clr_state_t;

endpackage

// File: rtl/spram_clear_ctrl.sv
// Zero-fill sequencer: walks every word once after reset or
// on request, holding off accesses until the sweep is done.
module spram_clear_ctrl
    import spram_pkg::*;
#(
    parameter int AWIDTH    = 11,
    parameter int NUM_WORDS = 2048
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_req,
    output logic              ready,
    output logic              clr_we,
    output logic [AWIDTH-1:0] clr_addr
);

    localparam logic [AWIDTH-1:0] LAST = AWIDTH'(NUM_WORDS - 1);

    clr_state_t        state, state_nx;
    logic [AWIDTH-1:0] cnt, cnt_nx;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CLR_CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            CLR_CLEAR: begin
                if (cnt == LAST) state_nx = CLR_IDLE;
                else             cnt_nx   = cnt + 1'b1;
            end
            CLR_IDLE: begin
                if (clear_req) begin
                    state_nx = CLR_CLEAR;
                    cnt_nx   = '0;
                end
            end
            default: state_nx = CLR_CLEAR;
        endcase
    end

    // clear_req wins over any access in the same cycle
    always_comb begin
        ready  = 1'b0;
        clr_we = 1'b0;
        unique case (state)
            CLR_CLEAR: clr_we = 1'b1;
            CLR_IDLE:  ready  = !clear_req;
            default:   clr_we = 1'b0;
        endcase
    end

    assign clr_addr = cnt;

endmodule

// File: rtl/spram_param_be.sv
// Byte-enabled single-port RAM with selectable write-collision
// behaviour, 1 or 2 cycle read latency and a zero-fill sweep.
module spram_param_be
    import spram_pkg::*;
#(
    parameter int AWIDTH     = 11,
    parameter int NUM_WORDS  = 2048,
    parameter int DWIDTH     = 60,
    parameter int BWIDTH     = 10,
    parameter int RD_LATENCY = 1,
    parameter int WR_MODE    = 1,
    localparam int NBYTES    = DWIDTH / BWIDTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    output logic              ready,
    input  logic              wren,
    input  logic [NBYTES-1:0] byte_en,
    input  logic [AWIDTH-1:0] address,
    input  logic [DWIDTH-1:0] data,
    input  logic              clear_req,
    output logic [DWIDTH-1:0] out,
    output logic              out_valid
);

    localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [AWIDTH:0] NW_L = (AWIDTH + 1)'(NUM_WORDS);

    logic [DWIDTH-1:0] mem [NUM_WORDS];

    logic              clr_we;
    logic [AWIDTH-1:0] clr_addr;
    logic              accept;
    logic              in_range;
    logic              issue;
    logic [IW-1:0]     rd_idx;
    logic [IW-1:0]     w_idx;
    logic [NBYTES-1:0] w_en;
    logic [DWIDTH-1:0] w_data;
    logic [DWIDTH-1:0] rd_word;
    logic [DWIDTH-1:0] ret_word;
    logic              p_valid;
    logic [DWIDTH-1:0] p_data;

    spram_clear_ctrl #(
        .AWIDTH    (AWIDTH),
        .NUM_WORDS (NUM_WORDS)
    ) u_clear (
        .clk       (clk),
        .reset     (reset),
        .clear_req (clear_req),
        .ready     (ready),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr)
    );

    assign accept   = req && ready;
    assign in_range = {1'b0, address} < NW_L;
    assign rd_idx   = address[IW-1:0];
    assign issue    = accept && (!wren || WR_MODE != WR_NO_CHANGE);
    assign rd_word  = in_range ? mem[rd_idx] : '0;

    // One shared write port: the sweep and user writes never overlap
    always_comb begin
        w_en   = '0;
        w_idx  = rd_idx;
        w_data = data;
        if (clr_we) begin
            w_en   = '1;
            w_idx  = clr_addr[IW-1:0];
            w_data = '0;
        end else if (accept && wren && in_range) begin
            w_en = byte_en;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NBYTES; i++) begin
            if (w_en[i])
                mem[w_idx][i*BWIDTH +: BWIDTH] <= w_data[i*BWIDTH +: BWIDTH];
        end
    end

    always_comb begin
        ret_word = rd_word;
        if (WR_MODE == WR_WRITE_FIRST && wren && in_range) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (byte_en[i])
                    ret_word[i*BWIDTH +: BWIDTH] = data[i*BWIDTH +: BWIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            p_valid <= 1'b0;
            p_data  <= '0;
        end else begin
            p_valid <= issue;
            if (issue) p_data <= ret_word;
        end
    end

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            always_ff @(posedge clk) begin
                if (reset) begin
                    out_valid <= 1'b0;
                    out       <= '0;
                end else begin
                    out_valid <= p_valid;
                    if (p_valid) out <= p_data;
                end
            end
        end else begin : g_lat1
            assign out_valid = p_valid;
            assign out       = p_data;
        end
    endgenerate

endmodule

// File: tb/tb_spram_param_be.sv
// Scoreboard bench: four RAM variants share one stimulus stream
// and are checked against an array model of the memory.
module tb_spram_param_be;

    localparam int AW = 11;
    localparam int DW = 60;
    localparam int BW = 10;
    localparam int NB = 6;

    localparam int NW   [4] = '{2048, 2048, 2048, 1000};
    localparam int MODE [4] = '{0, 1, 2, 1};
    localparam int LAT  [4] = '{1, 1, 2, 1};

    typedef struct {
        logic [DW-1:0] d;
        int            cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req = 1'b0;
    logic          wren = 1'b0;
    logic          clear_req = 1'b0;
    logic [NB-1:0] byte_en = '0;
    logic [AW-1:0] address = '0;
    logic [DW-1:0] data = '0;
    logic [DW-1:0] o   [4];
    logic          ov  [4];
    logic          rdy [4];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [DW-1:0] mdl  [4][2048];
    logic [DW-1:0] held [4];
    exp_t q0[$], q1[$], q2[$], q3[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spram_param_be #(.WR_MODE(0), .RD_LATENCY(1)) dut0 (
        .clk(clk), .reset(reset), .req(req), .ready(rdy[0]),
        .wren(wren), .byte_en(byte_en), .address(address),
        .data(data), .clear_req(clear_req), .out(o[0]),
        .out_valid(ov[0]));

    spram_param_be dut1 (
        .clk(clk), .reset(reset), .req(req), .ready(rdy[1]),
        .wren(wren), .byte_en(byte_en), .address(address),
        .data(data), .clear_req(clear_req), .out(o[1]),
        .out_valid(ov[1]));

    spram_param_be #(.WR_MODE(2), .RD_LATENCY(2)) dut2 (
        .clk(clk), .reset(reset), .req(req), .ready(rdy[2]),
        .wren(wren), .byte_en(byte_en), .address(address),
        .data(data), .clear_req(clear_req), .out(o[2]),
        .out_valid(ov[2]));

    spram_param_be #(.NUM_WORDS(1000)) dut3 (
        .clk(clk), .reset(reset), .req(req), .ready(rdy[3]),
        .wren(wren), .byte_en(byte_en), .address(address),
        .data(data), .clear_req(clear_req), .out(o[3]),
        .out_valid(ov[3]));

    function automatic void push_exp(int i, exp_t e);
        case (i)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            2:       q2.push_back(e);
            default: q3.push_back(e);
        endcase
    endfunction

    function automatic int qsize(int i);
        case (i)
            0:       return q0.size();
            1:       return q1.size();
            2:       return q2.size();
            default: return q3.size();
        endcase
    endfunction

    function automatic exp_t pop_exp(int i);
        case (i)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            2:       return q2.pop_front();
            default: return q3.pop_front();
        endcase
    endfunction

    function automatic int head_cyc(int i);
        case (i)
            0:       return q0[0].cyc;
            1:       return q1[0].cyc;
            2:       return q2[0].cyc;
            default: return q3[0].cyc;
        endcase
    endfunction

    // Monitor: every returned word must match the head of its queue
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            for (int i = 0; i < 4; i++) held[i] = '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (ov[i]) begin
                    checks++;
                    if (qsize(i) == 0) begin
                        errors++;
                        $display("FAIL spurious_valid inst%0d got %h want no valid",
                                 i, o[i]);
                    end else begin
                        e = pop_exp(i);
                        if (o[i] !== e.d || cyc != e.cyc) begin
                            errors++;
                            $display("FAIL read_data inst%0d got %h @%0d want %h @%0d",
                                     i, o[i], cyc, e.d, e.cyc);
                        end
                        held[i] = e.d;
                    end
                end else begin
                    if (qsize(i) > 0 && head_cyc(i) <= cyc) begin
                        e = pop_exp(i);
                        checks++;
                        errors++;
                        $display("FAIL missing_valid inst%0d got none @%0d want %h @%0d",
                                 i, cyc, e.d, e.cyc);
                    end
                    checks++;
                    if (o[i] !== held[i]) begin
                        errors++;
                        $display("FAIL out_hold inst%0d got %h want %h",
                                 i, o[i], held[i]);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rnd_word();
        logic [63:0] w;
        w = {$urandom(), $urandom()};
        return w[DW-1:0];
    endfunction

    task automatic access(input logic w, input logic [NB-1:0] be,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic [DW-1:0] old;
        logic [DW-1:0] nw;
        exp_t          e;
        bit            inr;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rdy[i] !== 1'b1) begin
                errors++;
                $display("FAIL ready_idle inst%0d got %b want 1", i, rdy[i]);
            end
        end
        req     = 1'b1;
        wren    = w;
        byte_en = be;
        address = a;
        data    = d;
        for (int i = 0; i < 4; i++) begin
            inr = int'(a) < NW[i];
            old = inr ? mdl[i][a] : '0;
            nw  = old;
            if (w && inr) begin
                for (int b = 0; b < NB; b++)
                    if (be[b]) nw[b*BW +: BW] = d[b*BW +: BW];
                mdl[i][a] = nw;
            end
            e.cyc = cyc + LAT[i];
            if (!w || MODE[i] == 0) begin
                e.d = old;
                push_exp(i, e);
            end else if (MODE[i] == 2) begin
                e.d = nw;
                push_exp(i, e);
            end
        end
        tick();
        req  = 1'b0;
        wren = 1'b0;
    endtask

    task automatic zero_model();
        for (int i = 0; i < 4; i++)
            for (int a = 0; a < 2048; a++) mdl[i][a] = '0;
    endtask

    task automatic measure_ready(input int pulse_at);
        int got [4];
        bit all;
        for (int i = 0; i < 4; i++) got[i] = -1;
        for (int n = 1; n <= 2200; n++) begin
            if (n == pulse_at) clear_req = 1'b1;
            tick();
            if (n == pulse_at) clear_req = 1'b0;
            all = 1'b1;
            for (int i = 0; i < 4; i++) begin
                if (got[i] < 0 && rdy[i] === 1'b1) got[i] = n;
                if (got[i] < 0) all = 1'b0;
            end
            if (all) break;
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got[i] != NW[i]) begin
                errors++;
                $display("FAIL ready_rise inst%0d got %0d want %0d",
                         i, got[i], NW[i]);
            end
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req       = 1'b0;
        clear_req = 1'b0;
        tick();
        q0.delete();
        q1.delete();
        q2.delete();
        q3.delete();
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rdy[i] !== 1'b0 || ov[i] !== 1'b0 || o[i] !== '0) begin
                errors++;
                $display("FAIL reset_state inst%0d got rdy=%b ov=%b out=%h want 0 0 0",
                         i, rdy[i], ov[i], o[i]);
            end
        end
        reset = 1'b0;
        zero_model();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] a;
        zero_model();
        #1;
        do_reset();
        measure_ready(0);

        access(1'b0, '0, 11'd5, '0);
        access(1'b1, 6'b111111, 11'h10, 60'h0123456789ABCDE);
        access(1'b0, '0, 11'h10, '0);
        access(1'b1, 6'b111111, 11'h20, 60'hFFFFFFFFFFFFFFF);
        access(1'b1, 6'b000001, 11'h20, '0);
        access(1'b0, '0, 11'h20, '0);
        access(1'b1, 6'b111111, 11'd3, 60'hA);
        access(1'b1, 6'b111111, 11'd3, 60'hB);
        access(1'b0, '0, 11'd3, '0);
        tick();

        for (int k = 1; k <= 3; k++)
            access(1'b1, 6'b111111, AW'(k), rnd_word());
        tick();
        for (int k = 1; k <= 3; k++)
            access(1'b0, '0, AW'(k), '0);
        tick();

        access(1'b1, 6'b000000, 11'h10, rnd_word());
        access(1'b0, '0, 11'h10, '0);
        access(1'b1, 6'b111111, 11'd1005, rnd_word());
        access(1'b0, '0, 11'd1005, '0);
        access(1'b1, 6'b101010, 11'd999, rnd_word());
        access(1'b0, '0, 11'd999, '0);
        tick();

        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 3) == 0)
                a = AW'($urandom_range(990, 1010));
            else
                a = AW'($urandom_range(0, 31));
            access(1'($urandom_range(0, 1)), NB'($urandom()), a, rnd_word());
            if ($urandom_range(0, 3) == 0) tick();
        end

        access(1'b0, '0, 11'd3, '0);
        clear_req = 1'b1;
        req       = 1'b1;
        wren      = 1'b0;
        address   = 11'h10;
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rdy[i] !== 1'b0) begin
                errors++;
                $display("FAIL clear_priority inst%0d got %b want 0", i, rdy[i]);
            end
        end
        tick();
        clear_req = 1'b0;
        req       = 1'b0;
        zero_model();
        measure_ready(50);
        access(1'b0, '0, 11'h10, '0);
        access(1'b0, '0, 11'd3, '0);
        access(1'b0, '0, 11'h20, '0);
        tick();

        access(1'b1, 6'b111111, 11'd7, rnd_word());
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        repeat (100) tick();
        do_reset();
        measure_ready(0);
        access(1'b0, '0, 11'd7, '0);
        access(1'b1, 6'b011110, 11'd8, rnd_word());
        access(1'b0, '0, 11'd8, '0);

        repeat (5) tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (qsize(i) != 0) begin
                errors++;
                $display("FAIL drain inst%0d got %0d pending want 0", i, qsize(i));
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
